// File: rtl/mult_accum_pkg.sv
// ============================================================================
// mult_accum_pkg : shared widths and FSM encoding for mult_accum_unit
// Revision 1.0
// ============================================================================
`default_nettype none

package mult_accum_pkg;

   localparam int OPND_W = 6;
   localparam int PROD_W = 12;
   localparam int ACC_W  = 18;
   localparam int CNT_W  = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/unsigned_array_mult.sv
// ============================================================================
// unsigned_array_mult : combinational 6x6 -> 12 unsigned shift-add array
// Revision 1.0
// ============================================================================
`default_nettype none

module unsigned_array_mult
   import mult_accum_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic [PROD_W-1:0] p
);

   always_comb begin
      p = '0;
      for (int i = 0; i < OPND_W; i++) begin
         if (b[i]) begin
            p = p + (PROD_W'(a) << i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mult_accum_unit.sv
// ============================================================================
// mult_accum_unit : blocked multiply-accumulate, two-stage product/add pipe
// Revision 1.0
// ============================================================================
`default_nettype none

module mult_accum_unit
   import mult_accum_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [5:0]        blk_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              busy
);

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   n_lat;
   logic [CNT_W-1:0]   cnt;
   logic [PROD_W-1:0]  prod_c;
   logic [PROD_W-1:0]  prod_r;
   logic               prod_vld;
   logic [ACC_W-1:0]   acc;
   logic               xfer;

   unsigned_array_mult u_mult (
      .a (a),
      .b (b),
      .p (prod_c)
   );

   assign in_ready  = (state == ST_ACCUM) && (cnt < n_lat);
   assign xfer      = in_valid && in_ready;
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign acc_out   = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ACCUM is held one cycle past the Nth transfer so the last product's add
   // lands before DRAIN; DONE therefore appears two edges after that transfer.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (start)          state_nx = ST_ACCUM;
         ST_ACCUM: if (cnt == n_lat)   state_nx = ST_DRAIN;
         ST_DRAIN:                     state_nx = ST_DONE;
         ST_DONE:  if (out_ready)      state_nx = ST_IDLE;
         default:                      state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lat    <= '0;
         cnt      <= '0;
         prod_r   <= '0;
         prod_vld <= 1'b0;
         acc      <= '0;
      end else begin
         prod_vld <= xfer;
         if (xfer) begin
            prod_r <= prod_c;
            cnt    <= cnt + CNT_W'(1);
         end
         if (state == ST_IDLE && start) begin
            n_lat <= CNT_W'(blk_len) + CNT_W'(1);
            cnt   <= '0;
            acc   <= '0;
         end else if (prod_vld) begin
            acc <= acc + ACC_W'(prod_r);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mult_accum_unit.sv
// ============================================================================
// tb_mult_accum_unit : directed scoreboard bench for mult_accum_unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mult_accum_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  blk_len;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  a;
   logic [5:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] acc_out;
   logic        busy;

   int          vec_cnt;
   int          err_cnt;
   int          model_sum;
   int          exp_q[$];

   mult_accum_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .blk_len   (blk_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_blk(input int len);
      start     = 1'b1;
      blk_len   = 6'(len);
      model_sum = 0;
      step();
      start     = 1'b0;
   endtask

   // One transfer; returns just after the transfer edge, then idles for gap.
   task automatic send(input int av, input int bv, input int gap);
      int n = 0;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      a        = 6'(av);
      b        = 6'(bv);
      model_sum += av * bv;
      step();
      in_valid = 1'b0;
      a        = 6'($urandom);
      b        = 6'($urandom);
      for (int i = 0; i < gap; i++) step();
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      int exp;
      while (!out_valid && n < 200) begin
         step();
         n++;
      end
      check({tag, "_out_valid"}, int'(out_valid), 1);
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 1, 0);
      end else begin
         exp = exp_q.pop_front();
         check({tag, "_acc"}, int'(acc_out), exp);
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_ov_clear"}, int'(out_valid), 0);
      check({tag, "_idle"}, int'(busy), 0);
   endtask

   initial begin
      int hold_acc;
      vec_cnt   = 0;
      err_cnt   = 0;
      model_sum = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      blk_len   = '0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_acc", int'(acc_out), 0);
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // in_valid in IDLE without start must not transfer
      in_valid = 1'b1;
      a        = 6'd40;
      b        = 6'd50;
      repeat (4) step();
      check("idle_in_ready", int'(in_ready), 0);
      check("idle_acc", int'(acc_out), 0);
      check("idle_busy", int'(busy), 0);
      in_valid = 1'b0;

      // single pair, exact latency
      start_blk(0);
      check("single_busy", int'(busy), 1);
      send(63, 63, 0);
      exp_q.push_back(model_sum);
      check("single_lat0", int'(out_valid), 0);
      check("single_ready_drop", int'(in_ready), 0);
      step();
      check("single_lat1", int'(out_valid), 0);
      step();
      check("single_lat2", int'(out_valid), 1);
      wait_out("single");
      handshake("single");

      // gapped four-pair block
      start_blk(3);
      send(13, 1, 2);
      send(9, 3, 0);
      send(60, 15, 3);
      send(36, 42, 1);
      exp_q.push_back(model_sum);
      wait_out("gapped");
      handshake("gapped");

      // 64 max-value pairs back-to-back, then DONE hold with start ignored
      start_blk(63);
      for (int i = 0; i < 64; i++) send(63, 63, 0);
      exp_q.push_back(model_sum);
      check("full_ready_drop", int'(in_ready), 0);
      wait_out("full");
      hold_acc = int'(acc_out);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         step();
         check("hold_ov", int'(out_valid), 1);
         check("hold_acc", int'(acc_out), hold_acc);
      end
      start = 1'b1;
      handshake("full");
      start = 1'b0;
      step();
      check("start_ignored", int'(busy), 0);

      // reset mid-block, then a fresh block
      start_blk(3);
      send(20, 20, 0);
      send(30, 30, 0);
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_ready", int'(in_ready), 0);
      check("mid_rst_ov", int'(out_valid), 0);
      check("mid_rst_acc", int'(acc_out), 0);
      step();
      rst_n = 1'b1;
      step();
      start_blk(1);
      send(5, 5, 1);
      send(2, 3, 0);
      exp_q.push_back(model_sum);
      wait_out("post_rst");
      handshake("post_rst");

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mult_accum_unit.md
MULT_ACCUM_UNIT -- requirements
Module: mult_accum_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 SHALL have ports, in order:
  clk        input   1   rising-edge clock
  rst_n      input   1   asynchronous active-low reset
  start      input   1   begin a block; sampled only in IDLE
  blk_len    input   6   block length minus one (N = blk_len+1, 1..64); latched on start
  in_valid   input   1   operand pair valid
  in_ready   output  1   unit accepts an operand pair
  a          input   6   unsigned multiplicand
  b          input   6   unsigned multiplier
  out_valid  output  1   acc_out holds a completed block sum
  out_ready  input   1   consumer takes acc_out
  acc_out    output  18  unsigned sum of N products
  busy       output  1   high in any state other than IDLE
REQ-003 SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 SHALL implement FSM states IDLE, ACCUM, DRAIN and DONE.
REQ-005 IDLE: start=1 SHALL latch N, clear the accumulator and operand count, and go to ACCUM next cycle.
REQ-006 ACCUM: in_ready=1 while the accepted count is below N; a transfer occurs on in_valid && in_ready.
REQ-007 SHALL register the 12-bit product a*b, computed combinationally, on the transfer edge (stage 1).
REQ-008 SHALL add the registered product into the 18-bit accumulator on the following edge (stage 2).
REQ-009 On the Nth transfer, in_ready SHALL drop the next cycle and the FSM SHALL go to DRAIN.
REQ-010 DRAIN SHALL last exactly one cycle (final add), then go to DONE.
REQ-011 Latency: Nth transfer at edge T -> out_valid=1 from edge T+2.
REQ-012 DONE: out_valid=1 and acc_out stable until out_ready=1, then go to IDLE with out_valid=0 on the next edge.
REQ-013 in_valid gaps in ACCUM SHALL stall accumulation with no effect on the sum.
REQ-014 start outside IDLE SHALL be ignored; start coincident with the DONE handshake SHALL be ignored (IDLE is re-entered first).
REQ-015 The 18-bit width SHALL make overflow impossible (max 64*3969 = 254016 < 2^18); no saturation logic.
REQ-016 acc_out SHALL show the running accumulator in ACCUM and DRAIN; only the DONE value is qualified by out_valid.
REQ-017 a and b SHALL be ignored when no transfer occurs.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, with in_ready=0, out_valid=0, busy=0, acc_out=0, product register=0, count=0 and latched N=0.
REQ-019 Reset mid-block SHALL discard the partial sum; the first block after reset SHALL be unaffected by it.

Structure
REQ-020 State encodings and widths (OPND_W=6, PROD_W=12, ACC_W=18, CNT_W=7) SHALL live in a shared package, mult_accum_pkg.
REQ-021 Stage 1 SHALL instantiate the existing combinational unsigned_array_mult (6x6->12) as its single sub-module.

Verification
REQ-022 blk_len=0, (63,63) -> out_valid two edges after the transfer, acc_out=3969.
REQ-023 blk_len=3, pairs (13,1),(9,3),(60,15),(36,42) with in_valid gaps of 0-3 cycles -> acc_out=2452.
REQ-024 blk_len=63, 64 pairs (63,63) back-to-back -> acc_out=254016, in_ready low after the 64th transfer.
REQ-025 out_ready held low 5 cycles in DONE -> acc_out and out_valid stable; start pulsed during DONE is ignored.
REQ-026 rst_n pulsed after 2 of 4 transfers -> all outputs 0 and state IDLE; a new block (5,5),(2,3) with blk_len=1 -> acc_out=31.
REQ-027 in_valid=1 in IDLE with no start -> no transfer; acc_out stays 0.
